scan_sequencer: RTL and testbench



---
 rtl/scan_sequencer.sv | 126 ++++++++++++
 tb/tb_scan_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a decoder select through the enabled Mask positions, holding each for DIV cycles.
//   Clock  in  rising-edge clock
//   Resetn in  asynchronous active-low reset
//   Run    in  level; 1 requests scanning, 0 forces idle
//   Mask   in  [7:0] Mask[i]=1 enables position i
//   W      out [2:0] registered current position (decoder select)
//   En     out registered decoder enable
//   Wrap   out registered one-cycle end-of-frame pulse
// Optional macro SCAN_BLANK_EN inserts BLANK_CYC blanking cycles (En=0) after every dwell.
module scan_sequencer #(
  parameter int DIV       = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Run,
  input  logic [7:0] Mask,
  output logic [2:0] W,
  output logic       En,
  output logic       Wrap
);
  if (DIV < 1 || DIV > 255 || BLANK_CYC < 1 || BLANK_CYC > 15) begin : g_bad_param
    $error("scan_sequencer: DIV or BLANK_CYC out of range");
  end
`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, BLANK = 2'd2} state_t;
  logic [3:0] bcnt, bcnt_d;
  logic [2:0] pend, pend_d;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1} state_t;
`endif
  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic [2:0] w_d, nxt;
  logic       en_d, wrap_d, dwell_end;
  function automatic logic [2:0] lowest(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) r = i[2:0];
    return r;
  endfunction
  // lowest enabled index above cur, falling back to the lowest overall
  function automatic logic [2:0] next_pos(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] r;
    r = lowest(m);
    for (int i = 7; i >= 0; i--) if (m[i] && i > int'(cur)) r = i[2:0];
    return r;
  endfunction
  assign dwell_end = (state == SCAN) && (cnt == 8'(DIV - 1));
  assign nxt = next_pos(Mask, W);
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    w_d     = W;
    en_d    = En;
    wrap_d  = 1'b0;
`ifdef SCAN_BLANK_EN
    bcnt_d  = bcnt;
    pend_d  = pend;
`endif
    if (!Run) begin
      state_d = IDLE;
      en_d    = 1'b0;
    end else begin
      case (state)
        IDLE: if (|Mask) begin
          state_d = SCAN;
          w_d     = lowest(Mask);
          en_d    = 1'b1;
          cnt_d   = 8'd0;
        end
        SCAN: if (!dwell_end) cnt_d = cnt + 8'd1;
        else if (~|Mask) begin
          state_d = IDLE;
          en_d    = 1'b0;
        end else begin
          wrap_d = (nxt <= W);
          cnt_d  = 8'd0;
`ifdef SCAN_BLANK_EN
          state_d = BLANK;
          en_d    = 1'b0;
          pend_d  = nxt;
          bcnt_d  = 4'd0;
`else
          w_d = nxt;
`endif
        end
`ifdef SCAN_BLANK_EN
        BLANK: if (bcnt == 4'(BLANK_CYC - 1)) begin
          state_d = SCAN;
          w_d     = pend;
          en_d    = 1'b1;
          cnt_d   = 8'd0;
        end else bcnt_d = bcnt + 4'd1;
`endif
        default: begin
          state_d = IDLE;
          en_d    = 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      cnt   <= 8'd0;
      W     <= 3'd0;
      En    <= 1'b0;
      Wrap  <= 1'b0;
`ifdef SCAN_BLANK_EN
      bcnt  <= 4'd0;
      pend  <= 3'd0;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      W     <= w_d;
      En    <= en_d;
      Wrap  <= wrap_d;
`ifdef SCAN_BLANK_EN
      bcnt  <= bcnt_d;
      pend  <= pend_d;
`endif
    end
  end
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: randomized and directed checks of scan_sequencer against a per-frame arithmetic model.
module tb_scan_sequencer;
  localparam int DIV = 4, BLANK_CYC = 2;
`ifdef SCAN_BLANK_EN
  localparam int BL = BLANK_CYC;
`else
  localparam int BL = 0;
`endif
  localparam int PER = DIV + BL;
  logic       Clock = 1'b0, Resetn = 1'b0, Run = 1'b0;
  logic [7:0] Mask = 8'h00;
  logic [2:0] W;
  logic       En, Wrap;
  int tests = 0, fails = 0;
  scan_sequencer #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .Mask(Mask), .W(W), .En(En), .Wrap(Wrap)
  );
  always #5 Clock = ~Clock;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end
  task automatic step;
    @(posedge Clock);
    #1;
  endtask
  // Expected outputs t cycles after the start edge with a constant nonzero mask:
  // position k occupies [k*PER, (k+1)*PER), enabled for its first DIV cycles.
  function automatic void model(input logic [7:0] m, input int t, output logic [2:0] ew, output logic een, output logic ewr);
    int pos[$];
    int k, idx;
    for (int i = 0; i < 8; i++) if (m[i]) pos.push_back(i);
    k   = t / PER;
    idx = k % pos.size();
    ew  = 3'(pos[idx]);
    een = (t % PER) < DIV;
    ewr = (BL > 0) ? ((t % PER == DIV) && ((k + 1) % pos.size() == 0)) : (t > 0 && t % PER == 0 && idx == 0);
  endfunction
  task automatic start_scan(input logic [7:0] m);
    Run = 1'b0;
    step();
    Mask = m;
    Run  = 1'b1;
    step();
  endtask
  task automatic test_reset;
    #12;
    tests++;
    if (W !== 3'd0 || En !== 1'b0 || Wrap !== 1'b0) begin
      fails++;
      $display("FAIL reset: W=%0d En=%b Wrap=%b, expected W=0 En=0 Wrap=0", W, En, Wrap);
    end
    step();
    Resetn = 1'b1;
    step();
  endtask
  task automatic test_frame(input string name, input logic [7:0] m, input int n);
    logic [2:0] ew;
    logic een, ewr;
    start_scan(m);
    for (int t = 0; t < n; t++) begin
      if (t > 0) step();
      model(m, t, ew, een, ewr);
      tests++;
      if (W !== ew || En !== een || Wrap !== ewr) begin
        fails++;
        $display("FAIL %s t=%0d: W=%0d En=%b Wrap=%b, expected W=%0d En=%b Wrap=%b", name, t, W, En, Wrap, ew, een, ewr);
      end
    end
  endtask
  task automatic test_zero_mask;
    logic [2:0] w0;
    Run = 1'b0;
    step();
    w0   = W;
    Mask = 8'h00;
    Run  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      tests++;
      if (En !== 1'b0 || Wrap !== 1'b0 || W !== w0) begin
        fails++;
        $display("FAIL zero_mask cyc=%0d: W=%0d En=%b Wrap=%b, expected W=%0d En=0 Wrap=0", i, W, En, Wrap, w0);
      end
    end
  endtask
  task automatic test_run_drop;
    start_scan(8'hFF);
    for (int i = 0; i < 64 && W !== 3'd3; i++) step();
    tests++;
    if (W !== 3'd3) begin
      fails++;
      $display("FAIL run_drop_reach: W=%0d, expected W=3 within 64 cycles", W);
    end
    Run = 1'b0;
    step();
    tests++;
    if (W !== 3'd3 || En !== 1'b0 || Wrap !== 1'b0) begin
      fails++;
      $display("FAIL run_drop: W=%0d En=%b Wrap=%b, expected W=3 En=0 Wrap=0", W, En, Wrap);
    end
    Mask = 8'hFF;
    Run  = 1'b1;
    step();
    tests++;
    if (W !== 3'd0 || En !== 1'b1) begin
      fails++;
      $display("FAIL run_restart: W=%0d En=%b, expected W=0 En=1", W, En);
    end
  endtask
  task automatic test_async_reset;
    start_scan(8'hFF);
    for (int i = 0; i < 64 && W !== 3'd5; i++) step();
    tests++;
    if (W !== 3'd5) begin
      fails++;
      $display("FAIL async_reset_reach: W=%0d, expected W=5 within 64 cycles", W);
    end
    #2;
    Resetn = 1'b0;
    #1;
    tests++;
    if (W !== 3'd0 || En !== 1'b0 || Wrap !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: W=%0d En=%b Wrap=%b, expected W=0 En=0 Wrap=0 before edge", W, En, Wrap);
    end
    Run = 1'b0;
    #2;
    Resetn = 1'b1;
    step();
  endtask
  task automatic test_mask_mid_dwell;
    logic [2:0] ew;
    logic een;
    start_scan(8'hFF);
    Mask = 8'h08;
    for (int t = 1; t <= PER; t++) begin
      step();
      ew  = (t < PER) ? 3'd0 : 3'd3;
      een = (t % PER) < DIV;
      tests++;
      if (W !== ew || En !== een || Wrap !== 1'b0) begin
        fails++;
        $display("FAIL mask_mid_dwell t=%0d: W=%0d En=%b Wrap=%b, expected W=%0d En=%b Wrap=0", t, W, En, Wrap, ew, een);
      end
    end
  endtask
  task automatic test_mask_zero_at_end;
    start_scan(8'hFF);
    Mask = 8'h00;
    for (int t = 1; t <= DIV; t++) begin
      step();
      tests++;
      if (W !== 3'd0 || En !== (t < DIV) || Wrap !== 1'b0) begin
        fails++;
        $display("FAIL mask_zero_end t=%0d: W=%0d En=%b Wrap=%b, expected W=0 En=%b Wrap=0", t, W, En, Wrap, t < DIV);
      end
    end
  endtask
  task automatic test_random;
    logic [7:0] m;
    logic [2:0] wl;
    int n;
    for (int r = 0; r < 15; r++) begin
      m = 8'($urandom_range(1, 255));
      n = $urandom_range(5, 60);
      test_frame("random", m, n);
      wl   = W;
      Run  = 1'b0;
      Mask = 8'($urandom);
      step();
      tests++;
      if (W !== wl || En !== 1'b0 || Wrap !== 1'b0) begin
        fails++;
        $display("FAIL random_drop mask=%h n=%0d: W=%0d En=%b Wrap=%b, expected W=%0d En=0 Wrap=0", m, n, W, En, Wrap, wl);
      end
    end
  endtask
  initial begin
    test_reset();
    test_frame("full_ff", 8'hFF, 2 * 8 * PER + 2);
    test_frame("sparse_a4", 8'hA4, 3 * 3 * PER + 1);
    test_frame("single_bit", 8'h10, 4 * PER + 1);
    test_zero_mask();
    test_run_drop();
    test_async_reset();
    test_frame("after_reset", 8'hA4, 2 * PER);
    test_mask_mid_dwell();
    test_mask_zero_at_end();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
